// File: rtl/rr_arb8_if.sv
// Request/grant bundle between requesters and the 8-way round-robin arbiter.
// The master drives req/done; the arbiter (slave) returns gnt/gnt_vld/tmo.
interface rr_arb8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       gnt_vld;
    logic       tmo;

    modport master (output req, output done, input gnt, input gnt_vld, input tmo);
    modport slave  (input req, input done, output gnt, output gnt_vld, output tmo);
endinterface

// File: rtl/rr_arb8.sv
// Purpose: 8-way round-robin arbiter; one-hot registered grant; optional tenure timeout (RR_TIMEOUT_EN).
// Latency: 1 cycle req->gnt; every release is followed by exactly one gnt==0 cycle.
// Backpressure: grant held until done, owner req drop or timeout; other requests wait, none are latched.
module rr_arb8 #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    rr_arb8_if.slave   arb
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_arb8: TIMEOUT must be in 1..255");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] idx;
    logic [2:0] sel;
    logic [7:0] gnt_q;
    logic       gnt_vld_q;
    logic       rel;

    // Scan from ptr upward (mod 8); the downward loop leaves the nearest set bit in sel.
    always_comb begin
        sel = ptr;
        for (int k = 7; k >= 0; k--) begin
            if (arb.req[3'(ptr + 3'(k))]) sel = ptr + 3'(k);
        end
    end

`ifdef RR_TIMEOUT_EN
    logic [7:0] cnt;
    logic       tmo_q;
    logic       tmo_hit;

    assign tmo_hit = (cnt == 8'(TIMEOUT - 1));
    assign rel     = arb.done | ~arb.req[idx] | tmo_hit;
    assign arb.tmo = tmo_q;
`else
    assign rel     = arb.done | ~arb.req[idx];
    assign arb.tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            idx       <= 3'd0;
            gnt_q     <= 8'h00;
            gnt_vld_q <= 1'b0;
`ifdef RR_TIMEOUT_EN
            cnt       <= 8'd0;
            tmo_q     <= 1'b0;
`endif
        end else begin
`ifdef RR_TIMEOUT_EN
            tmo_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|arb.req) begin
                        idx       <= sel;
                        gnt_q     <= 8'b1 << sel;
                        gnt_vld_q <= 1'b1;
                        state     <= GRANT;
`ifdef RR_TIMEOUT_EN
                        cnt       <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (rel) begin
                        // Dropping straight to zero gives the mandatory idle cycle before the next grant.
                        gnt_q     <= 8'h00;
                        gnt_vld_q <= 1'b0;
                        ptr       <= idx + 3'd1;
                        state     <= IDLE;
`ifdef RR_TIMEOUT_EN
                        tmo_q     <= tmo_hit;
`endif
                    end else begin
`ifdef RR_TIMEOUT_EN
                        cnt <= cnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arb.gnt     = gnt_q;
    assign arb.gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8: directed scenarios plus random traffic against a round-robin reference model.
module tb_rr_arb8;

`ifdef RR_TIMEOUT_EN
    localparam int TMO    = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 15;
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rr_arb8_if bus ();

    rr_arb8 #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_tmo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic d);
        bit drop, to;
        m_tmo = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < 8; k++) begin
                if (r[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_busy  = 1'b1;
                    m_cnt   = 0;
                    break;
                end
            end
        end else begin
            drop = !r[m_owner];
            to   = TMO_EN && (m_cnt == TMO - 1);
            if (d || drop || to) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % 8;
                m_tmo  = to;
            end else begin
                m_cnt++;
            end
        end
    endtask

    function automatic logic [2:0] enc8(input logic [7:0] v);
        logic [2:0] e;
        e = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) e = e | 3'(i);
        return e;
    endfunction

    task automatic cyc(input logic [7:0] r, input logic d);
        logic [7:0] exp_gnt;
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        exp_gnt = m_busy ? (8'h01 << m_owner) : 8'h00;
        chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
        chk("gnt_vld", 32'(bus.gnt_vld), 32'(m_busy));
        chk("tmo", 32'(bus.tmo), 32'(m_tmo));
        chk("onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
        if (bus.gnt_vld) chk("enc", 32'(enc8(bus.gnt)), 32'(m_owner));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_vld", 32'(bus.gnt_vld), 32'h0);
        chk("rst_tmo", 32'(bus.tmo), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_ord [9];
        logic [7:0] got [$];
        logic [7:0] prev;
        logic [7:0] r;

        bus.req  = 8'h00;
        bus.done = 1'b0;
        model_reset();
        #2;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_vld", 32'(bus.gnt_vld), 32'h0);
        chk("rst_tmo", 32'(bus.tmo), 32'h0);
        #10;
        rst_n = 1'b1;

        // first grant from ptr 0, then ptr moves past index 2
        cyc(8'h24, 1'b0); chk("s1_first", 32'(bus.gnt), 32'h04);
        cyc(8'h24, 1'b0); chk("s1_hold", 32'(bus.gnt), 32'h04);
        cyc(8'h24, 1'b1); chk("s1_gap", 32'(bus.gnt), 32'h00);
        cyc(8'h24, 1'b0); chk("s1_next", 32'(bus.gnt), 32'h20);
        cyc(8'h00, 1'b0);

        // full rotation with every requester active
        do_reset();
        exp_ord = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        prev = 8'h00;
        for (int i = 0; i < 27; i++) begin
            cyc(8'hFF, (i % 3) == 2);
            if (bus.gnt != 8'h00 && prev == 8'h00) got.push_back(bus.gnt);
            prev = bus.gnt;
        end
        chk("rr_count", 32'(got.size()), 32'd9);
        for (int j = 0; j < 9; j++) begin
            if (j < got.size()) chk("rr_order", 32'(got[j]), 32'(exp_ord[j]));
        end
        cyc(8'h00, 1'b0);

        // owner request drop releases; pointer then favours 5, later 6
        do_reset();
        cyc(8'h08, 1'b0); chk("s3_g3", 32'(bus.gnt), 32'h08);
        cyc(8'h20, 1'b0); chk("s3_drop", 32'(bus.gnt), 32'h00);
        cyc(8'h20, 1'b0); chk("s3_g5", 32'(bus.gnt), 32'h20);
        cyc(8'h20, 1'b1); chk("s3_rel", 32'(bus.gnt), 32'h00);
        cyc(8'h60, 1'b0); chk("s3_g6", 32'(bus.gnt), 32'h40);
        cyc(8'h00, 1'b0);

        // asynchronous reset in the middle of a grant
        do_reset();
        cyc(8'h40, 1'b0); chk("s4_g6", 32'(bus.gnt), 32'h40);
        #3;
        rst_n = 1'b0;
        #1;
        chk("s4_async_gnt", 32'(bus.gnt), 32'h00);
        chk("s4_async_vld", 32'(bus.gnt_vld), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        bus.req = 8'h41;
        rst_n   = 1'b1;
        cyc(8'h41, 1'b0); chk("s4_ptr0", 32'(bus.gnt), 32'h01);
        cyc(8'h00, 1'b0);

`ifdef RR_TIMEOUT_EN
        // tenure timeout: four grant cycles, tmo pulse, one idle cycle, regrant
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(8'h02, 1'b0); chk("s5_tenure", 32'(bus.gnt), 32'h02);
        end
        cyc(8'h02, 1'b0);
        chk("s5_gap", 32'(bus.gnt), 32'h00);
        chk("s5_tmo", 32'(bus.tmo), 32'h1);
        cyc(8'h02, 1'b0);
        chk("s5_regrant", 32'(bus.gnt), 32'h02);
        chk("s5_tmo_end", 32'(bus.tmo), 32'h0);
        cyc(8'h00, 1'b0);
`endif

        // random traffic: requests mostly held, occasional changes and done pulses
        do_reset();
        r = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 8'($urandom);
                if ($urandom_range(0, 1) == 0) r = r & 8'($urandom);
            end
            cyc(r, $urandom_range(0, 4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
